// File: rtl/conv_calc_pipe.sv
// Pipelined KSxKS multi-channel convolution with a programmable weight/bias bank,
// valid/ready back-pressure and a saturating output stage. Define CONV_RELU_EN to fuse ReLU at S3.
module conv_calc_pipe #(
    parameter int KS    = 5,
    parameter int NCH   = 3,
    parameter int DW    = 8,
    parameter int WW    = 4,
    parameter int BW    = 8,
    parameter int OW    = 12,
    parameter int SHIFT = 8,
    localparam int T    = KS * KS,
    localparam int NW   = NCH * T,
    localparam int AW   = (NW > 1) ? $clog2(NW) : 1,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_we,
    input  logic [AW-1:0]       w_addr,
    input  logic [WW-1:0]       w_data,
    input  logic                b_we,
    input  logic [CW-1:0]       b_addr,
    input  logic [BW-1:0]       b_data,
    output logic                wr_err,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [T*DW-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NCH*OW-1:0]   conv_out,
    output logic                busy
);

    localparam int PW   = DW + WW + 1;
    localparam int SW   = PW + $clog2(T);
    localparam int XW0  = (SW > BW) ? SW : BW;
    localparam int XW   = ((XW0 > OW) ? XW0 : OW) + 1;
    localparam int SMAX = (2 ** (OW - 1)) - 1;
    localparam int SMIN = -(2 ** (OW - 1));

`ifdef CONV_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic signed [WW-1:0] w_bank [NW];
    logic signed [BW-1:0] b_bank [NCH];

    logic v1, v2, v3;
    logic signed [PW-1:0] s1_prod  [NW];
    logic signed [PW-1:0] prod_nxt [NW];
    logic signed [SW-1:0] s2_sum   [NCH];
    logic signed [SW-1:0] sum_nxt  [NCH];
    logic signed [XW-1:0] biased   [NCH];
    logic signed [OW-1:0] res_nxt  [NCH];
    logic [NCH*OW-1:0]    s3_res;

    logic adv, wr_ok, w_ok, b_ok, wr_rej;

    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign busy      = v1 || v2 || v3;
    assign conv_out  = s3_res;

    // Writes only land with the pipe empty, so every window sees one coefficient set.
    assign wr_ok  = !busy && adv && !in_valid;
    assign w_ok   = w_we && wr_ok && (int'(w_addr) < NW);
    assign b_ok   = b_we && wr_ok && (int'(b_addr) < NCH);
    assign wr_rej = (w_we && !w_ok) || (b_we && !b_ok);

    always_comb begin
        for (int i = 0; i < NW; i++) begin
            prod_nxt[i] = $signed(PW'(w_bank[i])) * $signed(PW'(in_data[(i % T)*DW +: DW]));
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            sum_nxt[c] = '0;
            for (int t = 0; t < T; t++) begin
                sum_nxt[c] = sum_nxt[c] + SW'(s1_prod[c*T + t]);
            end
        end
    end

    // Floor shift, bias, then clamp; the wide intermediate keeps the clamp wrap-free.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            biased[c] = XW'(s2_sum[c] >>> SHIFT) + XW'(b_bank[c]);
            if (biased[c] > XW'(SMAX)) begin
                res_nxt[c] = OW'(SMAX);
            end else if (biased[c] < XW'(SMIN)) begin
                res_nxt[c] = OW'(SMIN);
            end else begin
                res_nxt[c] = OW'(biased[c]);
            end
            if (RELU && res_nxt[c][OW-1]) begin
                res_nxt[c] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            wr_err <= 1'b0;
            s3_res <= '0;
            for (int i = 0; i < NW; i++) begin
                w_bank[i]  <= '0;
                s1_prod[i] <= '0;
            end
            for (int c = 0; c < NCH; c++) begin
                b_bank[c] <= '0;
                s2_sum[c] <= '0;
            end
        end else begin
            if (adv) begin
                v1 <= in_valid;
                v2 <= v1;
                v3 <= v2;
                if (in_valid) begin
                    for (int i = 0; i < NW; i++) s1_prod[i] <= prod_nxt[i];
                end
                if (v1) begin
                    for (int c = 0; c < NCH; c++) s2_sum[c] <= sum_nxt[c];
                end
                if (v2) begin
                    for (int c = 0; c < NCH; c++) s3_res[c*OW +: OW] <= res_nxt[c];
                end
            end
            wr_err <= wr_rej;
            if (w_ok) w_bank[w_addr] <= w_data;
            if (b_ok) b_bank[b_addr] <= b_data;
        end
    end

endmodule

// File: tb/tb_conv_calc_pipe.sv
// Scoreboard bench for conv_calc_pipe: a default instance and an OW=8/SHIFT=0 instance
// share one stimulus stream; each has its own expected-result queue and monitor.
module tb_conv_calc_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, w_we, b_we, in_valid, out_ready;
    logic [6:0]   w_addr;
    logic [3:0]   w_data;
    logic [1:0]   b_addr;
    logic [7:0]   b_data;
    logic [199:0] in_data;

    logic        wr_err_a, in_ready_a, out_valid_a, busy_a;
    logic [35:0] conv_out_a;
    logic        wr_err_b, in_ready_b, out_valid_b, busy_b;
    logic [23:0] conv_out_b;

    conv_calc_pipe dut_a (
        .clk(clk), .rst(rst),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .wr_err(wr_err_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .conv_out(conv_out_a), .busy(busy_a)
    );

    conv_calc_pipe #(.OW(8), .SHIFT(0)) dut_b (
        .clk(clk), .rst(rst),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .wr_err(wr_err_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .conv_out(conv_out_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] q_a [$];
    logic [23:0] q_b [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int rl(input int v);
`ifdef CONV_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [35:0] pa(input int c0, input int c1, input int c2);
        logic [11:0] x0, x1, x2;
        x0 = 12'(rl(c0));
        x1 = 12'(rl(c1));
        x2 = 12'(rl(c2));
        return {x2, x1, x0};
    endfunction

    function automatic logic [23:0] pb(input int c0, input int c1, input int c2);
        logic [7:0] x0, x1, x2;
        x0 = 8'(rl(c0));
        x1 = 8'(rl(c1));
        x2 = 8'(rl(c2));
        return {x2, x1, x0};
    endfunction

    // Monitors: pop on every transfer, check hold behaviour while stalled.
    logic [35:0] held_a, exp_a;
    logic [23:0] held_b, exp_b;
    bit hold_a = 0, hold_b = 0;

    always @(negedge clk) begin
        if (!rst) begin
            hold_a = 0;
        end else if (out_valid_a) begin
            if (out_ready) begin
                hold_a = 0;
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_a unexpected: got 0x%0h, expected no output", conv_out_a);
                end else begin
                    exp_a = q_a.pop_front();
                    check("out_a", conv_out_a, exp_a);
                end
            end else begin
                check("in_ready_a during stall", in_ready_a, 0);
                if (hold_a) check("conv_out_a stable", conv_out_a, held_a);
                held_a = conv_out_a;
                hold_a = 1;
            end
        end else begin
            hold_a = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            hold_b = 0;
        end else if (out_valid_b) begin
            if (out_ready) begin
                hold_b = 0;
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_b unexpected: got 0x%0h, expected no output", conv_out_b);
                end else begin
                    exp_b = q_b.pop_front();
                    check("out_b", conv_out_b, exp_b);
                end
            end else begin
                check("in_ready_b during stall", in_ready_b, 0);
                if (hold_b) check("conv_out_b stable", conv_out_b, held_b);
                held_b = conv_out_b;
                hold_b = 1;
            end
        end else begin
            hold_b = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit ww, input int wa, input int wd, input bit bw, input int ba,
                      input int bd, input bit exp_err, input string name);
        w_we   = ww;
        w_addr = 7'(wa);
        w_data = 4'(wd);
        b_we   = bw;
        b_addr = 2'(ba);
        b_data = 8'(bd);
        tick();
        w_we = 1'b0;
        b_we = 1'b0;
        check({name, " wr_err_a"}, wr_err_a, exp_err);
        check({name, " wr_err_b"}, wr_err_b, exp_err);
    endtask

    // Presents a window until accepted; expected results are queued at acceptance.
    task automatic send(input logic [199:0] d, input bit push, input logic [35:0] ea,
                        input logic [23:0] eb);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            #3;
            acc = (in_ready_a === 1'b1);
            if (acc && push) begin
                q_a.push_back(ea);
                q_b.push_back(eb);
            end
            @(posedge clk);
            #1;
        end
        if (!acc) check("send accept timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (busy_a || busy_b); i++) tick();
        check("drain busy", {busy_a, busy_b}, 0);
    endtask

    function automatic logic [199:0] tap0(input int k);
        logic [199:0] d;
        d      = '0;
        d[7:0] = 8'(k);
        return d;
    endfunction

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; w_we = 1'b0; b_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        w_addr = '0; w_data = '0; b_addr = '0; b_data = '0; in_data = '0;
        tick();
        tick();
        check("rst out_valid_a", out_valid_a, 0);
        check("rst busy_a", busy_a, 0);
        check("rst conv_out_a", conv_out_a, 0);
        check("rst wr_err_a", wr_err_a, 0);
        check("rst out_valid_b", out_valid_b, 0);
        check("rst conv_out_b", conv_out_b, 0);
        rst = 1'b1;
        tick();
        check("idle in_ready_a", in_ready_a, 1);

        // Scenario 1: ch0 weights 7, pixels 255 -> 44625 >> 8 = 174
        for (int t = 0; t < 25; t++) wr(1, t, 7, 0, 0, 0, 0, "w ch0");
        send('1, 1, pa(174, 0, 0), pb(127, 0, 0));
        in_valid = 1'b0;
        check("latency edge1 a", out_valid_a, 0);
        tick();
        check("latency edge2 a", out_valid_a, 0);
        tick();
        check("latency edge3 a", out_valid_a, 1);
        check("latency edge3 b", out_valid_b, 1);
        wait_idle();
        wr(0, 0, 0, 1, 0, -128, 0, "b ch0");
        send('1, 1, pa(46, 0, 0), pb(127, 0, 0));
        in_valid = 1'b0;

        // Scenario 2: ch1 weights -8 -> floor(-199.2) = -200; ch2 weight+bias in one cycle
        wait_idle();
        for (int t = 25; t < 50; t++) wr(1, t, -8, 0, 0, 0, 0, "w ch1");
        wr(1, 50, 1, 1, 2, 5, 0, "w+b ch2");
        send('1, 1, pa(46, -200, 5), pb(127, -128, 127));
        in_valid = 1'b0;

        // Scenario 4: stream tap0 = 1..6 with a 4-cycle output stall mid-stream
        wait_idle();
        wr(1, 0, 1, 1, 0, 0, 0, "s4 setup");
        fork
            begin
                for (int k = 1; k <= 6; k++) send(tap0(k), 1, pa(0, -1, 5), pb(k, -8 * k, k + 5));
                in_valid = 1'b0;
            end
            begin
                tick();
                tick();
                tick();
                out_ready = 1'b0;
                repeat (4) tick();
                out_ready = 1'b1;
            end
        join

        // Scenario 5: rejected writes (busy, out-of-range) leave the bank untouched
        wait_idle();
        send(tap0(2), 1, pa(0, -1, 5), pb(2, -16, 7));
        in_valid = 1'b0;
        wr(1, 0, 3, 0, 0, 0, 1, "wr while busy");
        tick();
        check("wr_err one-cycle pulse", wr_err_a, 0);
        wait_idle();
        wr(1, 75, 3, 0, 0, 0, 1, "w_addr 75");
        wr(0, 0, 0, 1, 3, 100, 1, "b_addr 3");
        send(tap0(10), 1, pa(0, -1, 5), pb(10, -80, 15));
        in_valid = 1'b0;

        // Scenario 6: reset with two windows in flight
        wait_idle();
        send(tap0(3), 0, '0, '0);
        send(tap0(4), 0, '0, '0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("mid rst busy_a", busy_a, 0);
        check("mid rst busy_b", busy_b, 0);
        check("mid rst out_valid_a", out_valid_a, 0);
        rst = 1'b1;
        repeat (4) tick();
        check("post rst out_valid_a", out_valid_a, 0);
        send('1, 1, pa(0, 0, 0), pb(0, 0, 0));
        in_valid = 1'b0;

        wait_idle();
        repeat (2) tick();
        check("queue_a empty", q_a.size(), 0);
        check("queue_b empty", q_b.size(), 0);
        summary();
        $finish;
    end

endmodule
